// File: rtl/time_cmd_pkg.sv
// time_cmd_pkg: shared constants, state encoding and helpers for the time command controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package time_cmd_pkg;

  localparam logic [7:0] ASCII_S  = 8'h53;
  localparam logic [7:0] ASCII_G  = 8'h47;
  localparam logic [7:0] ASCII_K  = 8'h4B;
  localparam logic [7:0] ASCII_E  = 8'h45;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;

  localparam logic [6:0] MAX_HOUR   = 7'd23;
  localparam logic [6:0] MAX_MINSEC = 7'd59;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_S_DIGITS,
    ST_S_CR,
    ST_G_CR,
    ST_FLUSH,
    ST_APPLY,
    ST_TX
  } state_e;

  // Outgoing message buffer; byte 0 is transmitted first.
  typedef logic [7:0][7:0] msg_t;

  // Two decimal digits (tens, ones) to a 7-bit binary value.
  function automatic logic [6:0] dec2_to_bin(input logic [3:0] tens, input logic [3:0] ones);
    return 7'(tens) * 7'd10 + 7'(ones);
  endfunction

  // 7-bit binary value (0..99) to two ASCII digits {tens, ones}.
  function automatic logic [15:0] bin_to_ascii2(input logic [6:0] v);
    logic [6:0] tens;
    logic [6:0] ones;
    tens = v / 7'd10;
    ones = v % 7'd10;
    return {ASCII_0 + {1'b0, tens}, ASCII_0 + {1'b0, ones}};
  endfunction

endpackage

// File: rtl/time_tx_ser.sv
// time_tx_ser: serialises a 1- or 8-byte message onto a valid/ready byte port.
// Latency: first byte valid the cycle after start; one idle cycle between bytes.
// Backpressure: holds tx_data/tx_valid while tx_ready is low; done pulses on the last transfer.
module time_tx_ser
  import time_cmd_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  msg_t       msg_i,
  input  logic [3:0] len_i,
  input  logic       tx_ready_i,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  output logic       done_o
);

  msg_t       buf_q;
  logic [3:0] len_q;
  logic [2:0] idx_q;
  logic       active_q;
  logic       tx_valid_q;
  logic [7:0] tx_data_q;
  logic       last;
  logic       xfer;

  assign last       = ({1'b0, idx_q} == (len_q - 4'd1));
  assign xfer       = tx_valid_q & tx_ready_i;
  assign done_o     = xfer & last;
  assign tx_valid_o = tx_valid_q;
  assign tx_data_o  = tx_data_q;

  // Load on start, drop valid after each transfer, re-present the next byte one cycle later.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      buf_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      active_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else if (start_i) begin
      buf_q      <= msg_i;
      len_q      <= len_i;
      idx_q      <= '0;
      active_q   <= 1'b1;
      tx_valid_q <= 1'b1;
      tx_data_q  <= msg_i[0];
    end else if (xfer) begin
      tx_valid_q <= 1'b0;
      if (last) begin
        active_q <= 1'b0;
      end else begin
        idx_q     <= idx_q + 3'd1;
        tx_data_q <= buf_q[idx_q + 3'd1];
      end
    end else if (active_q) begin
      tx_valid_q <= 1'b1;
    end
  end

endmodule

// File: rtl/time_cmd_ctrl.sv
// time_cmd_ctrl: parses ASCII set/get commands from UART RX and drives the clock load port / TX replies.
// Latency: set pulse starts the cycle after the terminating CR; get/error reply valid the cycle after CR.
// Backpressure: RX bytes arriving during APPLY/TX are dropped; TX reply waits on tx_ready.
module time_cmd_ctrl
  import time_cmd_pkg::*;
#(
  parameter int HOLD_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic [6:0] cur_sec,
  input  logic [6:0] cur_min,
  input  logic [6:0] cur_hour,
  output logic       set_out,
  output logic       uart_sign_out,
  output logic [6:0] sec_uart,
  output logic [6:0] min_uart,
  output logic [6:0] hour_uart,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  state_e          state_q;
  logic [5:0][3:0] digs_q;
  logic [2:0]      dig_idx_q;
  logic [HW-1:0]   hold_q;
  logic [TW-1:0]   to_cnt_q;
  logic            set_q;
  logic            busy_q;
  logic [6:0]      sec_q, min_q, hour_q;

  logic       in_busy, parse_st, take, is_cr, is_digit, expire;
  logic       range_ok, set_cr, get_cr, err_cr, apply_end, ser_done;
  logic [6:0] hour_bin, min_bin, sec_bin;
  logic       tx_start;
  msg_t       tx_msg;
  logic [3:0] tx_len;
  logic [15:0] h_asc, m_asc, s_asc;

  assign in_busy  = (state_q == ST_APPLY) || (state_q == ST_TX);
  assign parse_st = (state_q == ST_S_DIGITS) || (state_q == ST_S_CR) ||
                    (state_q == ST_G_CR) || (state_q == ST_FLUSH);
  assign take     = rx_valid && !in_busy;
  assign is_cr    = (rx_data == ASCII_CR);
  assign is_digit = (rx_data >= ASCII_0) && (rx_data <= ASCII_9);
  // A byte in the expiry cycle is still accepted, so expiry requires no take.
  assign expire   = parse_st && !take && (to_cnt_q >= TO_LAST);

  assign hour_bin = dec2_to_bin(digs_q[0], digs_q[1]);
  assign min_bin  = dec2_to_bin(digs_q[2], digs_q[3]);
  assign sec_bin  = dec2_to_bin(digs_q[4], digs_q[5]);
  assign range_ok = (hour_bin <= MAX_HOUR) && (min_bin <= MAX_MINSEC) && (sec_bin <= MAX_MINSEC);

  assign set_cr    = take && is_cr && (state_q == ST_S_CR);
  assign get_cr    = take && is_cr && (state_q == ST_G_CR);
  assign err_cr    = take && is_cr && (((state_q == ST_S_CR) && !range_ok) || (state_q == ST_FLUSH));
  assign apply_end = (state_q == ST_APPLY) && (hold_q == HOLD_LAST);

  assign h_asc = bin_to_ascii2(cur_hour);
  assign m_asc = bin_to_ascii2(cur_min);
  assign s_asc = bin_to_ascii2(cur_sec);

  // Build the reply in the cycle it is launched so the get snapshot is taken with the CR.
  always_comb begin
    tx_start = get_cr || err_cr || apply_end;
    tx_msg   = '0;
    tx_len   = 4'd1;
    tx_msg[0] = ASCII_E;
    if (get_cr) begin
      tx_len    = 4'd8;
      tx_msg[0] = h_asc[15:8];
      tx_msg[1] = h_asc[7:0];
      tx_msg[2] = m_asc[15:8];
      tx_msg[3] = m_asc[7:0];
      tx_msg[4] = s_asc[15:8];
      tx_msg[5] = s_asc[7:0];
      tx_msg[6] = ASCII_CR;
      tx_msg[7] = ASCII_LF;
    end else if (apply_end) begin
      tx_msg[0] = ASCII_K;
    end
  end

  // Inter-byte idle counter: cleared by any accepted byte or outside the parse states, saturates.
  always_ff @(posedge clk) begin
    if (reset || !parse_st || take) begin
      to_cnt_q <= '0;
    end else if (to_cnt_q != TO_MAX) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  // Command FSM with registered set/busy/value outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      digs_q    <= '0;
      dig_idx_q <= '0;
      hold_q    <= '0;
      set_q     <= 1'b0;
      busy_q    <= 1'b0;
      sec_q     <= '0;
      min_q     <= '0;
      hour_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (take) begin
            if (rx_data == ASCII_S) begin
              state_q   <= ST_S_DIGITS;
              dig_idx_q <= '0;
            end else if (rx_data == ASCII_G) begin
              state_q <= ST_G_CR;
            end else if (!is_cr && (rx_data != ASCII_LF)) begin
              state_q <= ST_FLUSH;
            end
          end
        end
        ST_S_DIGITS: begin
          if (take) begin
            if (is_digit) begin
              digs_q[dig_idx_q] <= rx_data[3:0];
              if (dig_idx_q == 3'd5) state_q <= ST_S_CR;
              else                   dig_idx_q <= dig_idx_q + 3'd1;
            end else begin
              state_q <= ST_FLUSH;
            end
          end else if (expire) begin
            state_q <= ST_IDLE;
          end
        end
        ST_S_CR: begin
          if (take) begin
            if (!is_cr) begin
              state_q <= ST_FLUSH;
            end else if (range_ok) begin
              state_q <= ST_APPLY;
              busy_q  <= 1'b1;
              set_q   <= 1'b1;
              hold_q  <= '0;
              hour_q  <= hour_bin;
              min_q   <= min_bin;
              sec_q   <= sec_bin;
            end else begin
              state_q <= ST_TX;
              busy_q  <= 1'b1;
            end
          end else if (expire) begin
            state_q <= ST_IDLE;
          end
        end
        ST_G_CR, ST_FLUSH: begin
          if (take) begin
            if (is_cr) begin
              state_q <= ST_TX;
              busy_q  <= 1'b1;
            end else begin
              state_q <= ST_FLUSH;
            end
          end else if (expire) begin
            state_q <= ST_IDLE;
          end
        end
        ST_APPLY: begin
          if (apply_end) begin
            set_q   <= 1'b0;
            state_q <= ST_TX;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        ST_TX: begin
          if (ser_done) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          set_q   <= 1'b0;
        end
      endcase
    end
  end

  time_tx_ser u_tx_ser (
    .clk_i      (clk),
    .reset_i    (reset),
    .start_i    (tx_start),
    .msg_i      (tx_msg),
    .len_i      (tx_len),
    .tx_ready_i (tx_ready),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .done_o     (ser_done)
  );

  assign set_out       = set_q;
  assign uart_sign_out = set_q;
  assign busy          = busy_q;
  assign sec_uart      = sec_q;
  assign min_uart      = min_q;
  assign hour_uart     = hour_q;

endmodule

// File: tb/tb_time_cmd_ctrl.sv
// tb_time_cmd_ctrl: directed bench for time_cmd_ctrl with a TX byte scoreboard.
// Latency: checks set pulse, reply start cycle and timeout boundary cycle-exactly.
// Backpressure: tx_ready toggled during one reply to exercise stall stability.
module tb_time_cmd_ctrl;
  import time_cmd_pkg::*;

  localparam int HOLD = 2;
  localparam int TMO  = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [6:0] cur_sec, cur_min, cur_hour;
  logic       set_out, uart_sign_out;
  logic [6:0] sec_uart, min_uart, hour_uart;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;

  logic rdy_main, tgl_en, tgl_rdy;
  int   tgl_cnt;
  assign tx_ready = tgl_en ? tgl_rdy : rdy_main;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         set_cnt = 0;
  logic       stall_q = 1'b0;
  logic [7:0] stall_dat = '0;

  time_cmd_ctrl #(.HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .cur_sec(cur_sec), .cur_min(cur_min), .cur_hour(cur_hour),
    .set_out(set_out), .uart_sign_out(uart_sign_out),
    .sec_uart(sec_uart), .min_uart(min_uart), .hour_uart(hour_uart),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  // tx_ready pattern: flips every 3 cycles while enabled.
  always @(posedge clk) begin
    #1;
    if (!tgl_en) begin
      tgl_cnt = 0;
      tgl_rdy = 1'b0;
    end else begin
      tgl_cnt++;
      if (tgl_cnt == 3) begin
        tgl_rdy = ~tgl_rdy;
        tgl_cnt = 0;
      end
    end
  end

  // TX monitor: pops expected bytes on each transfer, checks stall stability, counts set cycles.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        checks++;
        assert (tx_valid === 1'b1 && tx_data === stall_dat) else begin
          errors++;
          $error("FAIL tx_stable observed valid=%b data=%h expected valid=1 data=%h", tx_valid, tx_data, stall_dat);
        end
      end
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL tx_unexpected observed=%h expected=no byte", tx_data);
        end
        if (exp_q.size() != 0) begin
          logic [7:0] e;
          e = exp_q.pop_front();
          checks++;
          assert (tx_data === e) else begin
            errors++;
            $error("FAIL tx_byte observed=%h expected=%h", tx_data, e);
          end
        end
      end
      stall_q   = (tx_valid === 1'b1) && (tx_ready === 1'b0);
      stall_dat = tx_data;
      if (set_out === 1'b1) set_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((busy !== 1'b0 || tx_valid !== 1'b0 || exp_q.size() != 0) && n < 400) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(n < 400), 32'd1);
  endtask

  initial begin
    int s0;
    int n;
    reset = 1'b1; rx_valid = 1'b0; rx_data = '0;
    rdy_main = 1'b1; tgl_en = 1'b0;
    cur_hour = '0; cur_min = '0; cur_sec = '0;
    tick(3);
    chk("rst_set_out", 32'(set_out), 32'd0);
    chk("rst_uart_sign", 32'(uart_sign_out), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_time", {11'd0, hour_uart, min_uart, sec_uart}, 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    reset = 1'b0;

    // Valid set: 12:34:56, pulse for HOLD cycles, then 'K'.
    s0 = set_cnt;
    exp_q.push_back(ASCII_K);
    send_str("S123456");
    send_byte(ASCII_CR);
    chk("set_n1_set_out", 32'(set_out), 32'd1);
    chk("set_n1_uart_sign", 32'(uart_sign_out), 32'd1);
    chk("set_n1_hour", 32'(hour_uart), 32'd12);
    chk("set_n1_min", 32'(min_uart), 32'd34);
    chk("set_n1_sec", 32'(sec_uart), 32'd56);
    chk("set_n1_tx_valid", 32'(tx_valid), 32'd0);
    chk("set_n1_busy", 32'(busy), 32'd1);
    tick(1);
    chk("set_n2_set_out", 32'(set_out), 32'd1);
    tick(1);
    chk("set_n3_set_out", 32'(set_out), 32'd0);
    chk("set_n3_tx_valid", 32'(tx_valid), 32'd1);
    chk("set_n3_tx_data", 32'(tx_data), 32'(ASCII_K));
    wait_done("set_done");
    chk("set_pulse_len", 32'(set_cnt - s0), 32'(HOLD));

    // Out-of-range hour: error reply, no pulse, values unchanged.
    s0 = set_cnt;
    exp_q.push_back(ASCII_E);
    send_str("S245900");
    send_byte(ASCII_CR);
    wait_done("range_done");
    chk("range_no_pulse", 32'(set_cnt - s0), 32'd0);
    chk("range_hold_time", {11'd0, hour_uart, min_uart, sec_uart}, {11'd0, 7'd12, 7'd34, 7'd56});

    // Get with tx_ready stalling.
    cur_hour = 7'd7; cur_min = 7'd5; cur_sec = 7'd9;
    tgl_en = 1'b1;
    push_str("070509");
    exp_q.push_back(ASCII_CR);
    exp_q.push_back(ASCII_LF);
    send_byte(ASCII_G);
    send_byte(ASCII_CR);
    chk("get_n1_tx_valid", 32'(tx_valid), 32'd1);
    chk("get_n1_tx_data", 32'(tx_data), 32'(ASCII_0));
    wait_done("get_done");
    tgl_en = 1'b0;

    // Malformed commands.
    s0 = set_cnt;
    exp_q.push_back(ASCII_E);
    send_str("S12X");
    send_byte(ASCII_CR);
    wait_done("nondigit_done");
    chk("nondigit_no_pulse", 32'(set_cnt - s0), 32'd0);
    exp_q.push_back(ASCII_E);
    send_byte("Q");
    send_byte(ASCII_CR);
    chk("badcmd_n1_tx_valid", 32'(tx_valid), 32'd1);
    chk("badcmd_n1_tx_data", 32'(tx_data), 32'(ASCII_E));
    wait_done("badcmd_done");

    // Set to zero; a get sent during APPLY is dropped.
    exp_q.push_back(ASCII_K);
    send_str("S000000");
    send_byte(ASCII_CR);
    send_byte(ASCII_G);
    send_byte(ASCII_CR);
    wait_done("drop_done");
    tick(5);
    chk("drop_no_extra_tx", 32'(tx_valid), 32'd0);
    chk("drop_time", {11'd0, hour_uart, min_uart, sec_uart}, 32'd0);

    // Byte arriving in the expiry cycle wins; boundary-maximum time is accepted.
    exp_q.push_back(ASCII_K);
    send_str("S23");
    tick(TMO - 1);
    chk("race_pre_state", 32'(dut.state_q), 32'(ST_S_DIGITS));
    send_byte("5");
    chk("race_post_state", 32'(dut.state_q), 32'(ST_S_DIGITS));
    send_str("959");
    send_byte(ASCII_CR);
    wait_done("race_done");
    chk("max_time", {11'd0, hour_uart, min_uart, sec_uart}, {11'd0, 7'd23, 7'd59, 7'd59});

    // Pure timeout: idle for TMO cycles abandons the partial set silently.
    send_str("S12");
    tick(TMO - 1);
    chk("tmo_before_state", 32'(dut.state_q), 32'(ST_S_DIGITS));
    tick(1);
    chk("tmo_after_state", 32'(dut.state_q), 32'(ST_IDLE));
    tick(3);
    chk("tmo_no_tx", 32'(tx_valid), 32'd0);
    cur_hour = 7'd23; cur_min = 7'd59; cur_sec = 7'd58;
    push_str("235958");
    exp_q.push_back(ASCII_CR);
    exp_q.push_back(ASCII_LF);
    send_byte(ASCII_G);
    send_byte(ASCII_CR);
    wait_done("tmo_get_done");

    // Reset in the middle of a get reply.
    cur_hour = 7'd7; cur_min = 7'd5; cur_sec = 7'd9;
    push_str("070509");
    exp_q.push_back(ASCII_CR);
    exp_q.push_back(ASCII_LF);
    send_byte(ASCII_G);
    send_byte(ASCII_CR);
    n = 0;
    while (exp_q.size() > 5 && n < 200) begin
      tick(1);
      n++;
    end
    chk("midtx_progress", 32'(n < 200), 32'd1);
    reset = 1'b1;
    tick(1);
    chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("midrst_set_out", 32'(set_out), 32'd0);
    chk("midrst_time", {11'd0, hour_uart, min_uart, sec_uart}, 32'd0);
    reset = 1'b0;
    exp_q.delete();
    tick(5);
    chk("midrst_stays_quiet", 32'(tx_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_cmd_ctrl.md
# time_cmd_ctrl

Command controller that sits between the UART receive/transmit byte interfaces and the digital clock counter. It parses ASCII set/get commands from the serial byte stream and range-checks set values. Valid sets are applied to the clock through its set/uart_sign/value inputs, and get requests are answered with a snapshot of the running time.

## Interface
- HOLD_CYCLES, 2: cycles set_out/uart_sign_out stay high per apply (≥1)
- TIMEOUT_CYCLES, 50000000: idle cycles between bytes before a partial command is abandoned
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- cur_sec, cur_min, cur_hour  in  7 each  live time from clock counter (binary)
- set_out  out  1  drives clock `set`
- uart_sign_out  out  1  drives clock `uart_sign`
- sec_uart, min_uart, hour_uart  out  7 each  binary time to load
- tx_data  out  8  byte to UART TX
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  TX accepts byte
- busy  out  1  high in any state except IDLE and parse states

## Operation
- Commands (uppercase ASCII only):
  - 'S' (0x53) + 6 digits HHMMSS + CR (0x0D) = set.
  - 'G' (0x47) + CR = get.
- States: IDLE, S_DIGITS, S_CR, G_CR, FLUSH, APPLY, TX.
- IDLE:
  - 'S' → S_DIGITS with digit index 0.
  - 'G' → G_CR.
  - CR/LF (0x0A) ignored.
  - Any other byte → FLUSH.
- S_DIGITS:
  - Accept bytes '0'..'9' and store them. After the 6th digit → S_CR.
  - A non-digit → FLUSH.
- S_CR:
  - On CR, convert each pair: value = tens*10 + ones, 7-bit.
  - If hour ≤ 23, min ≤ 59 and sec ≤ 59 → APPLY. Otherwise queue 'E' (0x45) → TX.
  - Any byte other than CR → FLUSH.
- G_CR:
  - On CR, snapshot cur_hour/min/sec and queue "HHMMSS\r\n" (8 bytes, two-digit decimal) → TX.
  - Any byte other than CR → FLUSH.
- FLUSH: discard bytes until CR, then queue 'E' → TX.
- APPLY:
  - Drive sec/min/hour_uart.
  - Hold set_out = uart_sign_out = 1 for HOLD_CYCLES cycles.
  - Then queue 'K' (0x4B) → TX.
- TX: send the queued bytes in order, then → IDLE.
- rx_valid while busy: byte dropped, no error.
- Timeout:
  - In S_DIGITS, S_CR, G_CR and FLUSH, a counter counts cycles since the last accepted byte.
  - At TIMEOUT_CYCLES → IDLE silently, with no response.
  - rx_valid in the same cycle as expiry wins: the byte is processed and the counter cleared.
- sec/min/hour_uart hold their last applied values until the next APPLY.

## Timing
- Reset values:
  - set_out, uart_sign_out, tx_valid, busy = 0.
  - tx_data = 0.
  - sec/min/hour_uart = 0.
  - State = IDLE, timeout counter = 0.
- Reset in any state: next cycle is IDLE and all outputs are at reset values. A partially sent TX message is abandoned.
- Terminating CR accepted in cycle N (set):
  - Values valid and set_out/uart_sign_out high in cycles N+1 .. N+HOLD_CYCLES.
  - tx_valid with 'K' first high in cycle N+HOLD_CYCLES+1.
- Terminating CR accepted in cycle N (get or error):
  - Snapshot is taken in cycle N.
  - tx_valid is high in cycle N+1.
- TX handshake:
  - A byte transfers on a cycle with tx_valid & tx_ready.
  - tx_data is stable while tx_valid & !tx_ready.
  - The next byte is presented in the cycle after a transfer, so at most 1 byte per 2 cycles.
  - tx_valid drops the cycle after the last byte transfers.
- Timeout counter width: $clog2(TIMEOUT_CYCLES+1). The counter saturates and never wraps.

## Structure
- Package time_cmd_pkg holds:
  - ASCII constants ('S','G','K','E',CR,LF,'0').
  - Limits MAX_HOUR=23, MAX_MINSEC=59.
  - State enum.
- Sub-module time_tx_ser:
  - Inputs: 8-byte message buffer, length (1 or 8), start strobe.
  - Runs the tx_valid/tx_ready handshake and returns a done pulse.
  - Binary→two-ASCII-digit conversion of the snapshot lives in the parent.

## Test plan
- "S123456\r", tx_ready=1:
  - set_out/uart_sign_out high for 2 cycles with hour=12, min=34, sec=56.
  - Then tx 'K'.
- "S245900\r": no set_out pulse, tx 'E', outputs unchanged from the previous apply.
- cur = 07:05:09, "G\r", tx_ready toggled every 3 cycles:
  - tx "070509\r\n" in order.
  - tx_data stable while stalled.
- "S12X\r": tx 'E', no apply. "Q\r": tx 'E'. "S12" followed by TIMEOUT_CYCLES idle cycles: returns to IDLE, no tx; a following "G\r" is answered normally.
- "S000000\r" with a second "G\r" sent during APPLY: second command dropped, only 'K' transmitted. Reset asserted mid-"070509" transmission: tx_valid 0 the next cycle, state IDLE.
